// File: rtl/cd_buf_pkg.sv
// Shared types and constants for the cd_buf page-based frame buffer.
// Page states, writer states, queue entry sizing and a saturating counter helper.
package cd_buf_pkg;

    typedef enum logic [1:0] {
        PG_FREE    = 2'd0,
        PG_FILLING = 2'd1,
        PG_READY   = 2'd2
    } page_st_e;

    typedef enum logic {
        WR_FILL   = 1'b0,
        WR_NOPAGE = 1'b1
    } wr_st_e;

    localparam int CD_PAGE_BITS = 2;
    localparam int CD_OFS_BITS  = 8;
    localparam int CD_PAGES     = 1 << CD_PAGE_BITS;
    localparam int CD_PAGE_SZ   = 1 << CD_OFS_BITS;

    // Ready-queue entry is {page, len}; len needs one extra bit for a full page.
    function automatic int entry_w(input int page_bits, input int ofs_bits);
        return page_bits + ofs_bits + 1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cd_buf_queue.sv
// Ready-queue FIFO of committed frames {page, len}; depth equals the page count,
// so it can never overflow while page ownership is respected.
module cd_buf_queue
    import cd_buf_pkg::*;
#(
    parameter int PAGE_BITS = CD_PAGE_BITS,
    parameter int OFS_BITS  = CD_OFS_BITS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_push,
    input  logic [PAGE_BITS+OFS_BITS:0]     i_entry,
    input  logic                            i_pop,
    output logic [PAGE_BITS+OFS_BITS:0]     o_head,
    output logic [PAGE_BITS:0]              o_count
);

    localparam int DEPTH = 1 << PAGE_BITS;
    localparam int EW    = entry_w(PAGE_BITS, OFS_BITS);

    logic [EW-1:0]        r_mem [DEPTH];
    logic [PAGE_BITS-1:0] r_wptr;
    logic [PAGE_BITS-1:0] r_rptr;
    logic [PAGE_BITS:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PAGE_BITS'(1);
            if (i_pop)  r_rptr <= r_rptr + PAGE_BITS'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PAGE_BITS+1)'(1);
                2'b01:   r_count <= r_count - (PAGE_BITS+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/cd_buf_ctrl.sv
// Page-based frame buffer controller in front of a 1R1W SRAM {page, offset}.
// Optional statistics outputs drop_cnt/ovf_cnt are built when CD_BUF_STAT_EN is defined.
module cd_buf_ctrl
    import cd_buf_pkg::*;
#(
    parameter int PAGE_BITS = CD_PAGE_BITS,
    parameter int OFS_BITS  = CD_OFS_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_commit,
    input  logic                          wr_abort,
    output logic                          wr_full,
    output logic                          rd_avail,
    output logic [OFS_BITS:0]             rd_len,
    input  logic                          rd_req,
    input  logic [OFS_BITS-1:0]           rd_ofs,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_done,
    output logic [PAGE_BITS+OFS_BITS-1:0] sram_ra,
    output logic [PAGE_BITS+OFS_BITS-1:0] sram_wa,
    output logic                          sram_re,
    output logic                          sram_we,
    output logic [7:0]                    sram_wd,
    input  logic [7:0]                    sram_rd
`ifdef CD_BUF_STAT_EN
    ,
    output logic [7:0]                    drop_cnt,
    output logic [7:0]                    ovf_cnt
`endif
);

    localparam int PAGES   = 1 << PAGE_BITS;
    localparam int PAGE_SZ = 1 << OFS_BITS;
    localparam int EW      = entry_w(PAGE_BITS, OFS_BITS);
    localparam logic [OFS_BITS:0] LEN_MAX = (OFS_BITS+1)'(PAGE_SZ);

    wr_st_e               r_wst;
    wr_st_e               w_wst_nxt;
    logic [PAGE_BITS-1:0] r_wpage;
    logic [OFS_BITS:0]    r_ofs;
    logic                 r_err;
    page_st_e             r_pst [PAGES];
    logic                 r_rd_vld_p1;

    logic                 w_own;
    logic                 w_wr_ok;
    logic                 w_drop_byte;
    logic                 w_err_eff;
    logic [OFS_BITS:0]    w_len;
    logic                 w_commit;
    logic                 w_frame_end;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_rd_fire;
    logic                 w_rd_avail;
    logic                 w_any_free;
    logic [PAGE_BITS-1:0] w_free_idx;
    logic                 w_alloc;
    logic [EW-1:0]        w_head;
    logic [PAGE_BITS-1:0] w_head_page;
    logic [OFS_BITS:0]    w_head_len;
    logic [PAGE_BITS:0]   w_q_count;

    // Writer side: a byte lands only while a page is owned and the page has room.
    assign w_own       = (r_wst == WR_FILL);
    assign w_wr_ok     = wr_en & w_own & (r_ofs < LEN_MAX);
    assign w_drop_byte = wr_en & ~w_wr_ok;
    assign w_err_eff   = r_err | w_drop_byte;
    assign w_len       = r_ofs + {{OFS_BITS{1'b0}}, w_wr_ok};
    assign w_commit    = wr_commit & ~wr_abort;
    assign w_frame_end = wr_commit | wr_abort;
    assign w_push      = w_commit & w_own & ~w_err_eff & (w_len != '0);

    assign w_rd_avail  = (w_q_count != '0);
    assign w_pop       = rd_done & w_rd_avail;
    assign w_rd_fire   = rd_req & w_rd_avail;
    assign w_head_page = w_head[EW-1 -: PAGE_BITS];
    assign w_head_len  = w_head[OFS_BITS:0];

    // Allocator only sees registered page states, so a page freed this cycle is usable next cycle.
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        for (int i = PAGES - 1; i >= 0; i--) begin
            if (r_pst[i] == PG_FREE) begin
                w_any_free = 1'b1;
                w_free_idx = PAGE_BITS'(i);
            end
        end
    end

    assign w_alloc = (w_push | ~w_own) & w_any_free;

    always_comb begin
        w_wst_nxt = r_wst;
        case (r_wst)
            WR_FILL:   if (w_push && !w_any_free) w_wst_nxt = WR_NOPAGE;
            WR_NOPAGE: if (w_any_free)            w_wst_nxt = WR_FILL;
            default:                              w_wst_nxt = WR_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_wst <= WR_FILL;
        else       r_wst <= w_wst_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wpage <= '0;
            r_ofs   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_alloc) r_wpage <= w_free_idx;
            if (w_frame_end) begin
                r_ofs <= '0;
                r_err <= 1'b0;
            end else begin
                r_ofs <= w_len;
                if (w_drop_byte) r_err <= 1'b1;
            end
        end
    end

    // Pop, push and allocate always touch distinct pages (READY, FILLING, FREE respectively).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PAGES; i++) r_pst[i] <= (i == 0) ? PG_FILLING : PG_FREE;
        end else begin
            if (w_pop)   r_pst[w_head_page] <= PG_FREE;
            if (w_push)  r_pst[r_wpage]     <= PG_READY;
            if (w_alloc) r_pst[w_free_idx]  <= PG_FILLING;
        end
    end

    cd_buf_queue #(
        .PAGE_BITS (PAGE_BITS),
        .OFS_BITS  (OFS_BITS)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_entry ({r_wpage, w_len}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_q_count)
    );

    // Read pipeline: request in p0, SRAM data returned with valid in p1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rd_vld_p1 <= 1'b0;
        else       r_rd_vld_p1 <= w_rd_fire;
    end

    assign wr_full  = ~w_own;
    assign rd_avail = w_rd_avail;
    assign rd_len   = w_rd_avail ? w_head_len : '0;
    assign rd_valid = r_rd_vld_p1;
    assign rd_data  = r_rd_vld_p1 ? sram_rd : 8'h00;
    assign sram_re  = w_rd_fire;
    assign sram_ra  = w_rd_fire ? {w_head_page, rd_ofs} : '0;
    assign sram_we  = w_wr_ok;
    assign sram_wa  = w_wr_ok ? {r_wpage, r_ofs[OFS_BITS-1:0]} : '0;
    assign sram_wd  = w_wr_ok ? wr_data : 8'h00;

`ifdef CD_BUF_STAT_EN
    logic       w_discard;
    logic [7:0] r_drop_cnt;
    logic [7:0] r_ovf_cnt;

    // Plain aborts and empty commits are not discards; only errored or page-less commits are.
    assign w_discard = w_commit & (w_err_eff | ~w_own);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= 8'h00;
            r_ovf_cnt  <= 8'h00;
        end else begin
            if (w_discard)   r_drop_cnt <= sat_inc8(r_drop_cnt);
            if (w_drop_byte) r_ovf_cnt  <= sat_inc8(r_ovf_cnt);
        end
    end

    assign drop_cnt = r_drop_cnt;
    assign ovf_cnt  = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_cd_buf_ctrl.sv
// Directed self-checking bench for cd_buf_ctrl (PAGE_BITS=2, OFS_BITS=8) with a 1-cycle SRAM model.
// Statistics checks are included when CD_BUF_STAT_EN is defined.
module tb_cd_buf_ctrl;
    import cd_buf_pkg::*;

    localparam int PB = 2;
    localparam int OB = 8;
    localparam int AW = PB + OB;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          wr_commit;
    logic          wr_abort;
    logic          wr_full;
    logic          rd_avail;
    logic [OB:0]   rd_len;
    logic          rd_req;
    logic [OB-1:0] rd_ofs;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          rd_done;
    logic [AW-1:0] sram_ra;
    logic [AW-1:0] sram_wa;
    logic          sram_re;
    logic          sram_we;
    logic [7:0]    sram_wd;
    logic [7:0]    sram_rd;
`ifdef CD_BUF_STAT_EN
    logic [7:0]    drop_cnt;
    logic [7:0]    ovf_cnt;
`endif

    int nerr;
    int nchk;
    logic [7:0] mem [1 << AW];

    cd_buf_ctrl #(.PAGE_BITS(PB), .OFS_BITS(OB)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_commit (wr_commit),
        .wr_abort  (wr_abort),
        .wr_full   (wr_full),
        .rd_avail  (rd_avail),
        .rd_len    (rd_len),
        .rd_req    (rd_req),
        .rd_ofs    (rd_ofs),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_done   (rd_done),
        .sram_ra   (sram_ra),
        .sram_wa   (sram_wa),
        .sram_re   (sram_re),
        .sram_we   (sram_we),
        .sram_wd   (sram_wd),
        .sram_rd   (sram_rd)
`ifdef CD_BUF_STAT_EN
        ,
        .drop_cnt  (drop_cnt),
        .ovf_cnt   (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_we) mem[sram_wa] <= sram_wd;
        if (sram_re) sram_rd <= mem[sram_ra];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wbyte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic commit();
        wr_commit = 1'b1;
        step();
        wr_commit = 1'b0;
    endtask

    task automatic pop();
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [OB-1:0] ofs, input logic [7:0] exp);
        rd_req = 1'b1;
        rd_ofs = ofs;
        step();
        rd_req = 1'b0;
        chk({tag, "_vld"}, rd_valid, 1);
        chk(tag, rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nerr = 0; nchk = 0;
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; wr_commit = 1'b0; wr_abort = 1'b0;
        rd_req = 1'b0; rd_ofs = '0; rd_done = 1'b0; sram_rd = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_full", wr_full, 0);
        chk("rst_rd_avail", rd_avail, 0);
        chk("rst_rd_len", rd_len, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_sram_re", sram_re, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_sram_wa", sram_wa, 0);
        chk("rst_sram_ra", sram_ra, 0);
`ifdef CD_BUF_STAT_EN
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_ovf_cnt", ovf_cnt, 0);
`endif
        reset = 1'b0;
        step();

        // Basic frame: 0x11..0x15 into page 0, read offset 2.
        wr_en = 1'b1; wr_data = 8'h11; #1;
        chk("t1_we", sram_we, 1);
        chk("t1_wa", sram_wa, 0);
        chk("t1_wd", sram_wd, 8'h11);
        step();
        for (int i = 1; i < 5; i++) wbyte(8'(8'h11 + i));
        commit();
        chk("t1_avail", rd_avail, 1);
        chk("t1_len", rd_len, 5);
        chk("t1_full", wr_full, 0);
        rd_req = 1'b1; rd_ofs = 8'd2; #1;
        chk("t1_re", sram_re, 1);
        chk("t1_ra", sram_ra, 2);
        step();
        rd_req = 1'b0;
        chk("t1_rd_vld", rd_valid, 1);
        chk("t1_rd_data", rd_data, 8'h13);
        step();
        chk("t1_vld_pulse", rd_valid, 0);
        pop();
        chk("t1_pop_avail", rd_avail, 0);
        chk("t1_pop_len", rd_len, 0);
        rd_req = 1'b1; rd_ofs = 8'd0; #1;
        chk("empty_re", sram_re, 0);
        step();
        rd_req = 1'b0;
        chk("empty_vld", rd_valid, 0);

        // Three frames of length 3, 7, 1 in pages 1, 0, 2.
        for (int i = 0; i < 3; i++) wbyte(8'(8'h20 + i));
        commit();
        for (int i = 0; i < 7; i++) wbyte(8'(8'h30 + i));
        commit();
        wbyte(8'h40);
        commit();
        chk("t5_len_a", rd_len, 3);
        rd_req = 1'b1; rd_ofs = 8'd1; #1;
        chk("t5_ra_a", sram_ra, 10'h101);
        step();
        rd_req = 1'b0;
        chk("t5_data_a", rd_data, 8'h21);
        pop();
        chk("t5_len_b", rd_len, 7);
        rd_req = 1'b1; rd_ofs = 8'd6; rd_done = 1'b1; #1;
        chk("t5_ra_b", sram_ra, 10'h006);
        step();
        rd_req = 1'b0; rd_done = 1'b0;
        chk("t5_vld_b", rd_valid, 1);
        chk("t5_data_b", rd_data, 8'h36);
        chk("t5_len_c", rd_len, 1);
        rd_req = 1'b1; rd_ofs = 8'd0; #1;
        chk("t5_ra_c", sram_ra, 10'h200);
        step();
        rd_req = 1'b0;
        chk("t5_data_c", rd_data, 8'h40);
        pop();
        chk("t5_empty", rd_avail, 0);

        // Byte with commit is counted; commit+abort discards.
        wbyte(8'h50);
        wbyte(8'h51);
        wr_en = 1'b1; wr_data = 8'h52; wr_commit = 1'b1;
        step();
        wr_en = 1'b0; wr_commit = 1'b0;
        chk("t4_len", rd_len, 3);
        rd_chk("t4_data", 8'd2, 8'h52);
        pop();
        wbyte(8'h60);
        wbyte(8'h61);
        wr_commit = 1'b1; wr_abort = 1'b1;
        step();
        wr_commit = 1'b0; wr_abort = 1'b0;
        chk("t4_ab_avail0", rd_avail, 0);
        step();
        chk("t4_ab_avail1", rd_avail, 0);
        chk("t4_ab_full", wr_full, 0);
        wr_en = 1'b1; wr_data = 8'h6A; #1;
        chk("t4_ab_ofs", sram_wa, 10'h000);
        step();
        wr_en = 1'b0;
        commit();
        chk("t4_ab_len", rd_len, 1);
        rd_chk("t4_ab_data", 8'd0, 8'h6A);
        pop();

        // Fill all pages without reading.
        for (int k = 0; k < CD_PAGES; k++) begin
            wbyte(8'(8'h71 + k));
            commit();
            chk("t2_full_step", wr_full, (k == CD_PAGES - 1) ? 1 : 0);
        end
        chk("t2_len", rd_len, 1);
        wr_en = 1'b1; wr_data = 8'h99; #1;
        chk("t2_drop_we", sram_we, 0);
        step();
        wr_en = 1'b0;
        commit();
        chk("t2_avail", rd_avail, 1);
        chk("t2_still_full", wr_full, 1);
        pop();
        chk("t2_full_1cyc", wr_full, 1);
        step();
        chk("t2_full_2cyc", wr_full, 0);
        rd_chk("t2_f2", 8'd0, 8'h72);
        pop();
        rd_chk("t2_f3", 8'd0, 8'h73);
        pop();
        rd_chk("t2_f4", 8'd0, 8'h74);
        pop();
        chk("t2_empty", rd_avail, 0);
`ifdef CD_BUF_STAT_EN
        chk("t2_ovf_cnt", ovf_cnt, 1);
        chk("t2_drop_cnt", drop_cnt, 1);
`endif

        // Oversized frame: PAGE_SZ+1 bytes, last one dropped, frame discarded.
        for (int i = 0; i < CD_PAGE_SZ + 1; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            if (i == CD_PAGE_SZ) begin
                #1;
                chk("t3_over_we", sram_we, 0);
            end
            step();
        end
        wr_en = 1'b0;
        commit();
        chk("t3_avail0", rd_avail, 0);
        step();
        chk("t3_avail1", rd_avail, 0);
`ifdef CD_BUF_STAT_EN
        chk("t3_ovf_cnt", ovf_cnt, 2);
        chk("t3_drop_cnt", drop_cnt, 2);
`endif
        wr_en = 1'b1; wr_data = 8'hAB; #1;
        chk("t3_page_kept", sram_wa, 10'h100);
        step();
        wr_en = 1'b0;
        commit();
        chk("t3_next_len", rd_len, 1);

        // Reset in the middle of a frame and a read.
        wbyte(8'hC1);
        rd_req = 1'b1; rd_ofs = 8'd0;
        step();
        chk("t6_mid_vld", rd_valid, 1);
        wr_en = 1'b1; wr_data = 8'hC2;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_avail", rd_avail, 0);
        chk("t6_full", wr_full, 0);
        chk("t6_vld", rd_valid, 0);
        chk("t6_re", sram_re, 0);
`ifdef CD_BUF_STAT_EN
        chk("t6_ovf_cnt", ovf_cnt, 0);
`endif
        rd_req = 1'b0; wr_en = 1'b0;
        step();
        reset = 1'b0;
        step();
        wr_en = 1'b1; wr_data = 8'hD1; #1;
        chk("t6_page0", sram_wa, 10'h000);
        step();
        wr_en = 1'b0;
        commit();
        chk("t6_len", rd_len, 1);
        rd_chk("t6_data", 8'd0, 8'hD1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
